// File: rtl/gbc_snd_frame_seq.sv
// gbc_snd_frame_seq: APU frame sequencer turning DIV tap falls into length/sweep/envelope strobes,
// with NR52 power gating, power-on first-event skip and ce/2, ce/4 enables.
module gbc_snd_frame_seq #(
   parameter bit SKIP_QUIRK = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       double_speed,
   input  logic [7:0] div_reg,
   input  logic       snd_enable,
   output logic       en_512,
   output logic       len_tick,
   output logic       sweep_tick,
   output logic       env_tick,
   output logic [2:0] step,
   output logic       len_next_skip,
   output logic       en_snd2,
   output logic       en_snd4
);
   logic       tap_q, tap_d, ds_q, ds_d, pwr_q, pwr_d, skip_q, skip_d;
   logic [2:0] step_q, step_d;
   logic [1:0] phase_q, phase_d;
   logic [3:0] strb_q, strb_d;
   logic       tap, fall, pwr_on, proc, off;
   logic       unused_div;
   assign unused_div = ^{div_reg[7:6], div_reg[3:0]};
   always_comb begin
      tap     = double_speed ? div_reg[5] : div_reg[4];
      fall    = ce & tap_q & ~tap & (ds_q == double_speed);
      off     = ce & ~snd_enable;
      pwr_on  = ce & snd_enable & ~pwr_q;
      // a fall coinciding with power-on is swallowed because pwr_q is still 0
      proc    = fall & snd_enable & pwr_q & ~skip_q;
      tap_d   = ce ? tap : tap_q;
      ds_d    = ce ? double_speed : ds_q;
      pwr_d   = ce ? snd_enable : pwr_q;
      phase_d = phase_q + {1'b0, ce};
      step_d  = off ? 3'd0 : proc ? step_q + 3'd1 : step_q;
      skip_d  = off ? 1'b0 : pwr_on ? (SKIP_QUIRK & tap) : (fall & skip_q) ? 1'b0 : skip_q;
      strb_d  = {proc, proc & ~step_q[0], proc & (step_q[1:0] == 2'd2), proc & (step_q == 3'd7)};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tap_q   <= 1'b0;
         ds_q    <= 1'b0;
         pwr_q   <= 1'b0;
         skip_q  <= 1'b0;
         step_q  <= 3'd0;
         phase_q <= 2'd0;
         strb_q  <= 4'd0;
      end else begin
         tap_q   <= tap_d;
         ds_q    <= ds_d;
         pwr_q   <= pwr_d;
         skip_q  <= skip_d;
         step_q  <= step_d;
         phase_q <= phase_d;
         strb_q  <= strb_d;
      end
   end
   assign {en_512, len_tick, sweep_tick, env_tick} = strb_q;
   assign step          = step_q;
   assign len_next_skip = step_q[0];
   assign en_snd2       = ce & phase_q[0];
   assign en_snd4       = ce & (&phase_q);
endmodule

// File: tb/tb_gbc_snd_frame_seq.sv
// tb_gbc_snd_frame_seq: directed checks of the frame sequencer strobes, power gating, skip quirk,
// double-speed tap selection, ce gating and dividers.
module tb_gbc_snd_frame_seq;
   logic       clk = 1'b0, reset = 1'b1, ce = 1'b1, double_speed = 1'b0, snd_enable = 1'b0;
   logic [7:0] div_reg = 8'd0;
   logic       en_512, len_tick, sweep_tick, env_tick, len_next_skip, en_snd2, en_snd4;
   logic [2:0] step;
   logic       z_en_512, z_len_tick, z_sweep_tick, z_env_tick, z_len_next_skip, z_en_snd2, z_en_snd4;
   logic [2:0] z_step;
   logic [3:0] strb, z_strb;
   int         checks = 0, failures = 0;
   assign strb   = {en_512, len_tick, sweep_tick, env_tick};
   assign z_strb = {z_en_512, z_len_tick, z_sweep_tick, z_env_tick};
   always #5 clk = ~clk;
   gbc_snd_frame_seq #(.SKIP_QUIRK(1'b1)) dut (
      .clk(clk), .reset(reset), .ce(ce), .double_speed(double_speed), .div_reg(div_reg),
      .snd_enable(snd_enable), .en_512(en_512), .len_tick(len_tick), .sweep_tick(sweep_tick),
      .env_tick(env_tick), .step(step), .len_next_skip(len_next_skip), .en_snd2(en_snd2),
      .en_snd4(en_snd4));
   gbc_snd_frame_seq #(.SKIP_QUIRK(1'b0)) dut0 (
      .clk(clk), .reset(reset), .ce(ce), .double_speed(double_speed), .div_reg(div_reg),
      .snd_enable(snd_enable), .en_512(z_en_512), .len_tick(z_len_tick), .sweep_tick(z_sweep_tick),
      .env_tick(z_env_tick), .step(z_step), .len_next_skip(z_len_next_skip), .en_snd2(z_en_snd2),
      .en_snd4(z_en_snd4));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1; ce = 1'b1; snd_enable = 1'b0; div_reg = 8'd0; double_speed = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask
   task automatic power_on();
      snd_enable = 1'b1;
      tick();
   endtask
   // one 1->0 transition of div_reg[b]; the resulting strobe is visible on return
   task automatic pulse_tap(input int b);
      div_reg[b] = 1'b1;
      tick();
      div_reg[b] = 1'b0;
      tick();
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({strb, step, len_next_skip, en_snd2, en_snd4} !== 9'd0) begin
         failures++;
         $display("FAIL reset_state got strb=%b step=%0d lns=%b s2=%b s4=%b want all 0",
                  strb, step, len_next_skip, en_snd2, en_snd4);
      end
   endtask
   task automatic test_sequence();
      logic [3:0] exp_s;
      logic [2:0] exp_step;
      do_reset();
      power_on();
      for (int k = 0; k < 8; k++) begin
         pulse_tap(4);
         exp_s    = {1'b1, (k % 2) == 0, (k % 4) == 2, k == 7};
         exp_step = 3'((k + 1) % 8);
         checks++;
         if (strb !== exp_s) begin
            failures++;
            $display("FAIL seq_strb k=%0d got=%b want=%b", k, strb, exp_s);
         end
         checks++;
         if (step !== exp_step || len_next_skip !== exp_step[0]) begin
            failures++;
            $display("FAIL seq_step k=%0d got=%0d/%b want=%0d/%b", k, step, len_next_skip,
                     exp_step, exp_step[0]);
         end
      end
      tick();
      checks++;
      if (strb !== 4'd0) begin
         failures++;
         $display("FAIL seq_width got=%b want=0000", strb);
      end
   endtask
   task automatic test_skip_quirk();
      do_reset();
      div_reg[4] = 1'b1;
      power_on();
      div_reg[4] = 1'b0;
      tick();
      checks++;
      if (strb !== 4'd0 || step !== 3'd0) begin
         failures++;
         $display("FAIL skip_first got strb=%b step=%0d want 0000 step 0", strb, step);
      end
      checks++;
      if (z_strb !== 4'b1100 || z_step !== 3'd1) begin
         failures++;
         $display("FAIL noskip_first got strb=%b step=%0d want 1100 step 1", z_strb, z_step);
      end
      pulse_tap(4);
      checks++;
      if (strb !== 4'b1100 || step !== 3'd1) begin
         failures++;
         $display("FAIL skip_second got strb=%b step=%0d want 1100 step 1", strb, step);
      end
   endtask
   task automatic test_double_speed();
      do_reset();
      double_speed = 1'b1;
      power_on();
      for (int k = 0; k < 3; k++) begin
         pulse_tap(4);
         checks++;
         if (strb !== 4'd0 || step !== 3'd0) begin
            failures++;
            $display("FAIL ds_div4 k=%0d got strb=%b step=%0d want 0000 step 0", k, strb, step);
         end
      end
      pulse_tap(5);
      checks++;
      if (strb !== 4'b1100 || step !== 3'd1) begin
         failures++;
         $display("FAIL ds_div5 got strb=%b step=%0d want 1100 step 1", strb, step);
      end
      div_reg[5] = 1'b1;
      tick();
      double_speed = 1'b0;
      tick();
      checks++;
      if (strb !== 4'd0 || step !== 3'd1) begin
         failures++;
         $display("FAIL ds_flip got strb=%b step=%0d want 0000 step 1", strb, step);
      end
      div_reg[5] = 1'b0;
      pulse_tap(4);
      checks++;
      if (strb !== 4'b1000 || step !== 3'd2) begin
         failures++;
         $display("FAIL ds_after got strb=%b step=%0d want 1000 step 2", strb, step);
      end
   endtask
   task automatic test_power_off();
      do_reset();
      power_on();
      for (int k = 0; k < 5; k++) pulse_tap(4);
      checks++;
      if (step !== 3'd5) begin
         failures++;
         $display("FAIL pwr_pre got step=%0d want 5", step);
      end
      snd_enable = 1'b0;
      tick();
      checks++;
      if (step !== 3'd0 || len_next_skip !== 1'b0) begin
         failures++;
         $display("FAIL pwr_off got step=%0d lns=%b want 0/0", step, len_next_skip);
      end
      for (int k = 0; k < 2; k++) begin
         pulse_tap(4);
         checks++;
         if (strb !== 4'd0 || step !== 3'd0) begin
            failures++;
            $display("FAIL pwr_off_fall k=%0d got strb=%b step=%0d want 0000 step 0", k, strb, step);
         end
      end
      power_on();
      pulse_tap(4);
      checks++;
      if (strb !== 4'b1100 || step !== 3'd1) begin
         failures++;
         $display("FAIL pwr_reon got strb=%b step=%0d want 1100 step 1", strb, step);
      end
   endtask
   task automatic test_ce_gating();
      logic e2, e4;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         ce = (i % 4) == 0;
         #1;
         e2 = ce && ((i / 4) % 2 == 1);
         e4 = ce && ((i / 4) % 4 == 3);
         checks++;
         if (en_snd2 !== e2 || en_snd4 !== e4) begin
            failures++;
            $display("FAIL divider i=%0d got s2=%b s4=%b want s2=%b s4=%b", i, en_snd2, en_snd4, e2, e4);
         end
         @(posedge clk);
         #1;
      end
      ce = 1'b1;
      power_on();
      div_reg[4] = 1'b1;
      tick();
      ce = 1'b0;
      div_reg[4] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (strb !== 4'd0 || step !== 3'd0) begin
            failures++;
            $display("FAIL ce_wait k=%0d got strb=%b step=%0d want 0000 step 0", k, strb, step);
         end
      end
      ce = 1'b1;
      tick();
      ce = 1'b0;
      checks++;
      if (strb !== 4'b1100 || step !== 3'd1) begin
         failures++;
         $display("FAIL ce_strobe got strb=%b step=%0d want 1100 step 1", strb, step);
      end
      tick();
      checks++;
      if (strb !== 4'd0) begin
         failures++;
         $display("FAIL ce_width got strb=%b want 0000", strb);
      end
      ce = 1'b1;
   endtask
   task automatic test_reset_mid();
      do_reset();
      power_on();
      for (int k = 0; k < 6; k++) pulse_tap(4);
      checks++;
      if (step !== 3'd6) begin
         failures++;
         $display("FAIL rmid_pre got step=%0d want 6", step);
      end
      reset = 1'b1;
      div_reg[4] = 1'b1;
      tick();
      checks++;
      if ({strb, step, len_next_skip, en_snd2, en_snd4} !== 9'd0) begin
         failures++;
         $display("FAIL rmid_state got strb=%b step=%0d lns=%b s2=%b s4=%b want all 0",
                  strb, step, len_next_skip, en_snd2, en_snd4);
      end
      reset = 1'b0;
      div_reg[4] = 1'b0;
      tick();
      pulse_tap(4);
      checks++;
      if (strb !== 4'b1100 || step !== 3'd1) begin
         failures++;
         $display("FAIL rmid_after got strb=%b step=%0d want 1100 step 1", strb, step);
      end
      pulse_tap(4);
      pulse_tap(4);
      checks++;
      if (strb !== 4'b1110 || step !== 3'd3) begin
         failures++;
         $display("FAIL back_to_back got strb=%b step=%0d want 1110 step 3", strb, step);
      end
   endtask
   initial begin
      test_reset();
      test_sequence();
      test_skip_quirk();
      test_double_speed();
      test_power_off();
      test_ce_gating();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
